// File: rtl/world_clock_pkg.sv
// Shared constants for the world-clock local timekeeping stage.
package world_clock_pkg;
  localparam int FIELD_W     = 7;
  localparam int WC_W        = 3;
  localparam int SEC_MAX     = 59;
  localparam int MIN_MAX     = 59;
  localparam int HOUR_MAX    = 23;
  localparam int W_COUNT_MAX = 3;

  localparam logic [1:0] RUN_ST   = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
endpackage

// File: rtl/world_time_counter_if.sv
// Control/status bundle between the timekeeper and its user (buttons in, time out).
interface world_time_counter_if;
  import world_clock_pkg::*;
  logic               RUN;
  logic               MODE_BTN;
  logic               SET_BTN;
  logic               INC_BTN;
  logic [FIELD_W-1:0] SEC;
  logic [FIELD_W-1:0] MIN;
  logic [FIELD_W-1:0] HOUR;
  logic [WC_W-1:0]    W_COUNT;
  logic               SEC_TICK;
  logic [1:0]         SET_STATE;

  modport master (output RUN, MODE_BTN, SET_BTN, INC_BTN,
                  input  SEC, MIN, HOUR, W_COUNT, SEC_TICK, SET_STATE);
  modport slave  (input  RUN, MODE_BTN, SET_BTN, INC_BTN,
                  output SEC, MIN, HOUR, W_COUNT, SEC_TICK, SET_STATE);
endinterface

// File: rtl/mod_wrap_counter.sv
// Modulo-(MAX+1) counter; carry is high on the increment that wraps MAX to 0.
module mod_wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 7
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] r_value;

  assign carry = inc && (r_value == MAXV);
  assign value = r_value;

  always_ff @(posedge clk) begin
    if (!rstn)     r_value <= '0;
    else if (clr)  r_value <= '0;
    else if (inc)  r_value <= carry ? '0 : r_value + 1'b1;
  end
endmodule

// File: rtl/world_time_counter.sv
// Local 24h time of day with 1 Hz prescaler and city selector.
// Optional set-mode FSM enabled by defining WORLD_TIME_SET_EN.
module world_time_counter
  import world_clock_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  world_time_counter_if.slave  bus
);
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]      r_presc;
  logic               r_sec_tick;
  logic [1:0]         w_state;
  logic               w_enter_set, w_leave_set, w_inc_hour, w_inc_min;
  logic               w_run_en, w_tick;
  logic [FIELD_W-1:0] w_sec, w_min, w_hour;
  logic [WC_W-1:0]    w_wc;
  logic               w_sec_carry, w_min_carry, w_hour_carry, w_wc_carry;
  logic               w_unused;

`ifdef WORLD_TIME_SET_EN
  logic [1:0] r_state;

  always_ff @(posedge CLK) begin
    if (!RESETN) r_state <= RUN_ST;
    else if (bus.SET_BTN) begin
      case (r_state)
        RUN_ST:   r_state <= SET_HOUR;
        SET_HOUR: r_state <= SET_MIN;
        default:  r_state <= RUN_ST;
      endcase
    end
  end

  assign w_state     = r_state;
  assign w_enter_set = bus.SET_BTN && (r_state == RUN_ST);
  assign w_leave_set = bus.SET_BTN && (r_state == SET_MIN);
  // SET_BTN has priority: a coincident INC_BTN is dropped
  assign w_inc_hour  = bus.INC_BTN && !bus.SET_BTN && (r_state == SET_HOUR);
  assign w_inc_min   = bus.INC_BTN && !bus.SET_BTN && (r_state == SET_MIN);
  assign w_unused    = &{1'b0, w_hour_carry, w_wc_carry};
`else
  assign w_state     = RUN_ST;
  assign w_enter_set = 1'b0;
  assign w_leave_set = 1'b0;
  assign w_inc_hour  = 1'b0;
  assign w_inc_min   = 1'b0;
  assign w_unused    = &{1'b0, w_hour_carry, w_wc_carry, bus.SET_BTN, bus.INC_BTN};
`endif

  assign w_run_en = bus.RUN && (w_state == RUN_ST);
  assign w_tick   = w_run_en && (r_presc == PRESC_MAX);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      if (w_tick || w_enter_set || w_leave_set) r_presc <= '0;
      else if (w_run_en)                        r_presc <= r_presc + 1'b1;
    end
  end

  mod_wrap_counter #(.MAX(SEC_MAX), .W(FIELD_W)) u_sec (
    .clk(CLK), .rstn(RESETN), .inc(w_tick), .clr(w_leave_set),
    .value(w_sec), .carry(w_sec_carry));

  mod_wrap_counter #(.MAX(MIN_MAX), .W(FIELD_W)) u_min (
    .clk(CLK), .rstn(RESETN), .inc((w_tick && w_sec_carry) || w_inc_min), .clr(1'b0),
    .value(w_min), .carry(w_min_carry));

  // Manual minute edits must not ripple into the hour
  mod_wrap_counter #(.MAX(HOUR_MAX), .W(FIELD_W)) u_hour (
    .clk(CLK), .rstn(RESETN),
    .inc((w_min_carry && (w_state == RUN_ST)) || w_inc_hour), .clr(1'b0),
    .value(w_hour), .carry(w_hour_carry));

  mod_wrap_counter #(.MAX(W_COUNT_MAX), .W(WC_W)) u_wc (
    .clk(CLK), .rstn(RESETN), .inc(bus.MODE_BTN), .clr(1'b0),
    .value(w_wc), .carry(w_wc_carry));

  assign bus.SEC       = w_sec;
  assign bus.MIN       = w_min;
  assign bus.HOUR      = w_hour;
  assign bus.W_COUNT   = w_wc;
  assign bus.SEC_TICK  = r_sec_tick;
  assign bus.SET_STATE = w_state;
endmodule
